// File: rtl/measure_pkg.sv
// Shared XGMII control characters, receive FSM states and decoded control flags
// for the latency measurement block.
package measure_pkg;

  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;
  localparam logic [7:0] XGMII_IDLE  = 8'h07;

  localparam int unsigned WC_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_DROP
  } rx_state_e;

  typedef struct packed {
    logic sof;
    logic term;
    logic err;
  } ctrl_flags_t;

endpackage

// File: rtl/xgmii_ctrl_decode.sv
// Combinational decode of one 64-bit XGMII word into start, terminate and error flags.
module xgmii_ctrl_decode
  import measure_pkg::*;
(
  input  logic [63:0]  rxd,
  input  logic [7:0]   rxc,
  output ctrl_flags_t  flags_c
);

  // Start is only legal in lane 0; terminate/error may sit in any control lane
  always_comb begin
    flags_c     = '0;
    flags_c.sof = (rxc == 8'h01) && (rxd[7:0] == XGMII_START);
    for (int n = 0; n < 8; n++) begin
      if (rxc[n] && (rxd[8*n +: 8] == XGMII_TERM))  flags_c.term = 1'b1;
      if (rxc[n] && (rxd[8*n +: 8] == XGMII_ERROR)) flags_c.err  = 1'b1;
    end
  end

endmodule

// File: rtl/xgmii_rx_latency.sv
// Receive-side one-way latency measurement on XGMII measurement frames.
// Define RX_LATENCY_STATS_EN to build the min/max latency trackers.
module xgmii_rx_latency
  import measure_pkg::*;
#(
  parameter int unsigned TS_W       = 32,
  parameter logic [31:0] MAGIC      = 32'hA5A5_5A5A,
  parameter int unsigned MAGIC_WORD = 6
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic [63:0]     xgmii_rxd,
  input  logic [7:0]      xgmii_rxc,
  input  logic [TS_W-1:0] global_counter,
  input  logic            clear,
  output logic [TS_W-1:0] latency,
  output logic            latency_valid,
  output logic [31:0]     pkt_count,
  output logic [15:0]     err_count,
  output logic [TS_W-1:0] lat_min,
  output logic [TS_W-1:0] lat_max
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned ERR_W = 16;
  localparam int unsigned IDX_W = WC_W + 1;

  ctrl_flags_t       flags_c;
  rx_state_e         state, nxt_state_c;
  logic [WC_W-1:0]   word_cnt;
  logic [IDX_W-1:0]  word_idx_c;
  logic              at_magic_c, magic_ok_c;
  logic              start_c, capture_tx_c, commit_c, err_inc_c, wc_inc_c;
  logic [TS_W-1:0]   ts_rx, ts_tx, lat_new_c;

  xgmii_ctrl_decode u_decode (
    .rxd     (xgmii_rxd),
    .rxc     (xgmii_rxc),
    .flags_c (flags_c)
  );

  // word_cnt holds the index of the previous word; the current word is one beyond it
  assign word_idx_c = IDX_W'(word_cnt) + IDX_W'(1);
  assign at_magic_c = (word_idx_c == IDX_W'(MAGIC_WORD));
  assign magic_ok_c = (xgmii_rxd[31:0] == MAGIC);
  assign lat_new_c  = ts_rx - ts_tx;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= nxt_state_c;
  end

  always_comb begin
    nxt_state_c  = state;
    start_c      = 1'b0;
    capture_tx_c = 1'b0;
    commit_c     = 1'b0;
    err_inc_c    = 1'b0;
    wc_inc_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (flags_c.sof) begin
          start_c     = 1'b1;
          nxt_state_c = ST_HDR;
        end
      end
      ST_HDR: begin
        wc_inc_c = 1'b1;
        if (flags_c.sof) begin
          start_c     = 1'b1;
          err_inc_c   = 1'b1;
          nxt_state_c = ST_HDR;
        end else if (flags_c.err) begin
          err_inc_c   = 1'b1;
          nxt_state_c = flags_c.term ? ST_IDLE : ST_DROP;
        end else if (flags_c.term) begin
          nxt_state_c = ST_IDLE;
        end else if (at_magic_c) begin
          capture_tx_c = magic_ok_c;
          nxt_state_c  = magic_ok_c ? ST_PAYLOAD : ST_DROP;
        end
      end
      ST_PAYLOAD: begin
        if (flags_c.sof) begin
          start_c     = 1'b1;
          err_inc_c   = 1'b1;
          nxt_state_c = ST_HDR;
        end else if (flags_c.err) begin
          err_inc_c   = 1'b1;
          nxt_state_c = flags_c.term ? ST_IDLE : ST_DROP;
        end else if (flags_c.term) begin
          commit_c    = 1'b1;
          nxt_state_c = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (flags_c.sof) begin
          start_c     = 1'b1;
          err_inc_c   = 1'b1;
          nxt_state_c = ST_HDR;
        end else if (flags_c.term) begin
          nxt_state_c = ST_IDLE;
        end
      end
      default: nxt_state_c = ST_IDLE;
    endcase
  end

  // Timestamps, word counter, latency result and saturating frame counters
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ts_rx         <= '0;
      ts_tx         <= '0;
      word_cnt      <= '0;
      latency       <= '0;
      latency_valid <= 1'b0;
      pkt_count     <= '0;
      err_count     <= '0;
    end else begin
      latency_valid <= commit_c;
      if (commit_c) latency <= lat_new_c;
      if (start_c) begin
        ts_rx    <= global_counter;
        word_cnt <= '0;
      end else if (wc_inc_c && (word_cnt != '1)) begin
        word_cnt <= word_cnt + WC_W'(1);
      end
      if (capture_tx_c) ts_tx <= TS_W'(xgmii_rxd[63:32]);
      if (clear) begin
        pkt_count <= '0;
        err_count <= '0;
      end else begin
        if (commit_c && (pkt_count != '1))  pkt_count <= pkt_count + CNT_W'(1);
        if (err_inc_c && (err_count != '1)) err_count <= err_count + ERR_W'(1);
      end
    end
  end

`ifdef RX_LATENCY_STATS_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst || clear) begin
      lat_min <= '1;
      lat_max <= '0;
    end else if (commit_c) begin
      if (lat_new_c < lat_min) lat_min <= lat_new_c;
      if (lat_new_c > lat_max) lat_max <= lat_new_c;
    end
  end
`else
  assign lat_min = '1;
  assign lat_max = '0;
`endif

endmodule

// File: doc/xgmii_rx_latency.md
XGMII_RX_LATENCY -- requirements
Module: xgmii_rx_latency

Interface
REQ-001 Parameter TS_W, 32, width of timestamp, global counter and latency.
REQ-002 Parameter MAGIC, 32'hA5A5_5A5A, measurement-frame signature.
REQ-003 Parameter MAGIC_WORD, 6, index of the 64-bit word after SOF holding the signature in rxd[31:0] and the TX timestamp in rxd[63:32]; SOF word is index 0.
REQ-004 sys_clk  input  1  sole clock.
REQ-005 sys_rst  input  1  reset; synchronous, active-high.
REQ-006 xgmii_rxd  input  64  XGMII data; lane n = bits [8n+7:8n], lane 0 first on wire.
REQ-007 xgmii_rxc  input  8  XGMII control; bit n qualifies lane n.
REQ-008 global_counter  input  TS_W  free-running time base, same domain as the TX timestamp.
REQ-009 clear  input  1  synchronous statistics clear.
REQ-010 latency  output  TS_W  last measured latency.
REQ-011 latency_valid  output  1  one-cycle pulse when latency updates.
REQ-012 pkt_count  output  32  accepted measurement frames.
REQ-013 err_count  output  16  aborted or errored frames.
REQ-014 lat_min  output  TS_W  minimum latency since clear.
REQ-015 lat_max  output  TS_W  maximum latency since clear.

Function
REQ-016 SOF is detected only in lane 0: rxc==8'h01 and rxd[7:0]==8'hFB.
REQ-017 TERM is any lane n with rxc[n]=1 and byte 8'hFD; ERR is any lane n with rxc[n]=1 and byte 8'hFE.
REQ-018 FSM states are IDLE, HDR, PAYLOAD, and DROP.
REQ-019 IDLE: on SOF, capture global_counter into ts_rx, clear the word counter, and go to HDR.
REQ-020 HDR: increment the word counter each cycle; at MAGIC_WORD, with no TERM/ERR in that word, go to PAYLOAD if rxd[31:0]==MAGIC (latching rxd[63:32] as ts_tx), else go to DROP.
REQ-021 PAYLOAD: on TERM without ERR, go to IDLE and commit the result.
REQ-022 Any ERR in HDR or PAYLOAD, including in the TERM word, increments err_count and goes to DROP, or to IDLE if that word also holds TERM.
REQ-023 TERM in HDR at or before MAGIC_WORD is a short frame: go to IDLE with no commit and no error.
REQ-024 DROP: go to IDLE on TERM.
REQ-025 SOF in HDR, PAYLOAD, or DROP aborts the current frame, increments err_count, and restarts as in REQ-019 in the same cycle.
REQ-026 Commit: latency = ts_rx - ts_tx modulo 2^TS_W; latency_valid pulses in the cycle after the TERM word; pkt_count increments; lat_min and lat_max update against the new value.
REQ-027 pkt_count and err_count saturate at all-ones.
REQ-028 The word counter is 4 bits and saturates at 15.
REQ-029 clear zeroes pkt_count and err_count, sets lat_min to all-ones and lat_max to 0, and leaves latency and the FSM untouched; clear wins over a commit or error in the same cycle, and that update is lost.

Reset
REQ-030 sys_rst forces IDLE, latency=0, latency_valid=0, pkt_count=0, err_count=0, lat_min=all-ones, and lat_max=0.
REQ-031 Reset mid-frame discards the frame with no counter change; the next SOF after reset release is decoded normally.

Configuration
REQ-032 With RX_LATENCY_STATS_EN defined, lat_min and lat_max behave per REQ-026 and REQ-029.
REQ-033 Without RX_LATENCY_STATS_EN, lat_min is constant all-ones, lat_max is constant 0, and no comparator logic is instantiated.

Structure
REQ-034 Shared package measure_pkg holds the XGMII control characters (START 8'hFB, TERM 8'hFD, ERROR 8'hFE, IDLE 8'h07) and the FSM state enum.
REQ-035 Sub-module xgmii_ctrl_decode is combinational and produces sof, term, and err flags from rxd/rxc; all other logic is in xgmii_rx_latency.

Verification
REQ-036 Scenario 1: global_counter=1000 at SOF, word 6 = {32'd940, MAGIC}, TERM in word 9 -> latency=60, one latency_valid pulse, pkt_count=1, lat_min=lat_max=60.
REQ-037 Scenario 2: two frames with latencies 60 then 25, then clear -> lat_min=25, lat_max=60, pkt_count=2; after clear, pkt_count=0, lat_min=FFFFFFFF, lat_max=0.
REQ-038 Scenario 3: ts_tx=32'hFFFF_FFF0 and ts_rx=32'h10 -> latency=32'h20.
REQ-039 Scenario 4: frame with wrong signature 32'h1234_5678 -> no pulse, pkt_count unchanged, err_count unchanged.
REQ-040 Scenario 5: 0xFE in lane 3 with rxc bit 3 set at word 8 -> err_count=1, no pulse; a following good frame is accepted.
REQ-041 Scenario 6: new SOF at word 4 of a frame -> err_count=1, and the second frame (latency 100) is accepted with pkt_count=1.
